vector_loader: RTL and testbench
================================

VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 Parameter NUM_BANKS, default 8, number of MCU shared-memory banks to load.
REQ-002 Parameter WORDS_PER_BANK, default 2, vector words written into each bank (bank addresses 0..WORDS_PER_BANK-1).
REQ-003 Parameter FRAC_BITS, default 8, left shift applied to each 16-bit vector when it is placed in a 32-bit word.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin a load.
REQ-008 stall  input  1  while high in LOAD, the current word is not written and the index does not advance.
REQ-009 rom_addr  output  4  test-vector ROM word index.
REQ-010 rom_ce  output  1  ROM output enable.
REQ-011 rom_data  input  16  ROM word, combinational from rom_addr in the same cycle.
REQ-012 bank_we  output  NUM_BANKS  one-hot write enable for the bank being loaded.
REQ-013 bank_addr  output  2  word address within the bank.
REQ-014 bank_wdata  output  32  formatted vector word.
REQ-015 mcu_hold  output  1  high holds every MCU core in reset.
REQ-016 busy  output  1  high while in LOAD.
REQ-017 done  output  1  high while in DONE.

Function
REQ-018 The block SHALL implement three states: IDLE, LOAD and DONE.
REQ-019 IDLE SHALL go to LOAD on start=1; otherwise it SHALL stay in IDLE.
REQ-020 On entry to LOAD the index k SHALL be 0; total words N = NUM_BANKS*WORDS_PER_BANK (16).
REQ-021 In LOAD, rom_addr=k and rom_ce=1.
REQ-022 In LOAD with stall=0, bank_we SHALL be one-hot at bit k/WORDS_PER_BANK, bank_addr = k mod WORDS_PER_BANK, and k SHALL increment.
REQ-023 bank_wdata SHALL equal sign-extend(rom_data) << FRAC_BITS, i.e. {8 copies of rom_data[15], rom_data, 8'h00} at default parameters.
REQ-024 In LOAD with stall=1, bank_we SHALL be all zero and k SHALL hold.
REQ-025 LOAD SHALL go to DONE on the cycle after the write of k=N-1 (no wrap past N-1).
REQ-026 Outside LOAD, bank_we=0, rom_ce=0, rom_addr=0, bank_addr=0 and bank_wdata=0.
REQ-027 mcu_hold SHALL be 1 in IDLE and LOAD, and 0 in DONE.
REQ-028 Latency: with start at cycle 0 and no stall, writes occur in cycles 1..16, and done=1 with mcu_hold=0 from cycle 17.
REQ-029 start while in LOAD SHALL be ignored.
REQ-030 start while in DONE SHALL re-enter LOAD with k=0, and mcu_hold SHALL rise in that same cycle.
REQ-031 start and stall high together in IDLE SHALL still enter LOAD; the stall takes effect from the first LOAD cycle.
REQ-032 All outputs SHALL be registered state or decoded combinationally from state, k and rom_data only.

Reset
REQ-033 rst=1 SHALL force state to IDLE and k to 0 on the next edge, regardless of current state, including in the middle of a LOAD.
REQ-034 Reset values: bank_we=0, rom_ce=0, rom_addr=0, bank_addr=0, bank_wdata=0, busy=0, done=0, mcu_hold=1.
REQ-035 rst SHALL take priority over start and stall.

Structure
REQ-036 The state encoding, NUM_BANKS, WORDS_PER_BANK and FRAC_BITS defaults SHALL live in a shared package used by this block and its downstream result readout.
REQ-037 The sign-extend-and-shift formatting SHALL be one sub-module, q_format_pack, reused by the result path.
REQ-038 The block SHALL contain no memory; the banks remain in Common_mem.

Verification
REQ-039 Reset, then start with no stall and ROM[k]=k+1 -> bank b receives words 2b+1 at address 0 and 2b+2 at address 1, done=1 at cycle 17.
REQ-040 rom_data=16'h8001 -> bank_wdata=32'hFF800100; rom_data=16'h7FFF -> 32'h007FFF00.
REQ-041 stall held high for 3 cycles at k=5 -> no writes in those cycles, k=5 written once afterwards, done at cycle 20.
REQ-042 rst pulsed at k=9 -> IDLE, outputs at reset values, mcu_hold=1; a new start reloads from k=0.
REQ-043 start pulsed at k=4 and again in DONE -> the first is ignored; the second gives mcu_hold=1 in the same cycle and 16 fresh writes.

Source files
------------

// File: rtl/vector_loader_pkg.sv
// Shared definitions for the vector loader and the result readout path.
// Holds the loader state encoding and the default bank/format geometry.
package vector_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_BANKS_DEF      = 8;
    localparam int WORDS_PER_BANK_DEF = 2;
    localparam int FRAC_BITS_DEF      = 8;

    localparam int VEC_W     = 16;
    localparam int WORD_W    = 32;
    localparam int ROM_AW    = 4;
    localparam int BANK_AW   = 2;

endpackage

// File: rtl/q_format_pack.sv
// Sign-extends a 16-bit vector to 32 bits and shifts it into Q format.
// Purely combinational, zero latency; no flow control.
module q_format_pack
    import vector_loader_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic [VEC_W-1:0]  vec_dat,
    output logic [WORD_W-1:0] word_dat
);

    logic [WORD_W-1:0] ext_dat;

    assign ext_dat  = WORD_W'(signed'(vec_dat));
    assign word_dat = ext_dat << FRAC_BITS;

endmodule

// File: rtl/vector_loader.sv
// Copies the test-vector ROM into the MCU shared-memory banks while holding the cores in reset.
// One word per LOAD cycle, done the cycle after the last write; stall freezes the index.
module vector_loader
    import vector_loader_pkg::*;
#(
    parameter int NUM_BANKS      = NUM_BANKS_DEF,
    parameter int WORDS_PER_BANK = WORDS_PER_BANK_DEF,
    parameter int FRAC_BITS      = FRAC_BITS_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stall,
    output logic [ROM_AW-1:0]    rom_addr,
    output logic                 rom_ce,
    input  logic [VEC_W-1:0]     rom_data,
    output logic [NUM_BANKS-1:0] bank_we,
    output logic [BANK_AW-1:0]   bank_addr,
    output logic [WORD_W-1:0]    bank_wdata,
    output logic                 mcu_hold,
    output logic                 busy,
    output logic                 done
);

    localparam int N  = NUM_BANKS * WORDS_PER_BANK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [WORD_W-1:0] fmt_dat;
    int              k_int;

    q_format_pack #(.FRAC_BITS(FRAC_BITS)) u_fmt (
        .vec_dat  (rom_data),
        .word_dat (fmt_dat)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        k_int      = int'(k_q);
        rom_addr   = '0;
        rom_ce     = 1'b0;
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        mcu_hold   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                end
            end
            ST_LOAD: begin
                busy       = 1'b1;
                rom_ce     = 1'b1;
                rom_addr   = ROM_AW'(k_q);
                bank_addr  = BANK_AW'(k_int % WORDS_PER_BANK);
                bank_wdata = fmt_dat;
                if (!stall) begin
                    bank_we = NUM_BANKS'(1) << (k_int / WORDS_PER_BANK);
                    // Last word leaves LOAD instead of wrapping the index.
                    if (k_q == KW'(N - 1)) begin
                        state_d = ST_DONE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                mcu_hold = 1'b0;
                if (start) begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_vector_loader.sv
// Directed bench for vector_loader: reset, formatting, full load, stall, mid-load reset, restart.
module tb_vector_loader;

    logic        clk_in;
    logic        rst;
    logic        start;
    logic        stall;
    logic [3:0]  rom_addr;
    logic        rom_ce;
    logic [15:0] rom_data;
    logic [7:0]  bank_we;
    logic [1:0]  bank_addr;
    logic [31:0] bank_wdata;
    logic        mcu_hold;
    logic        busy;
    logic        done;

    logic [15:0] rom_mem [16];
    logic        rom_override;
    logic [15:0] rom_force;
    logic [31:0] bank_mem [8][2];

    int n_cmp;
    int n_err;

    vector_loader dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .rom_addr   (rom_addr),
        .rom_ce     (rom_ce),
        .rom_data   (rom_data),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .mcu_hold   (mcu_hold),
        .busy       (busy),
        .done       (done)
    );

    assign rom_data = rom_override ? rom_force : rom_mem[rom_addr];

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        stall = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || mcu_hold !== 1'b1) begin
            n_err++;
            $display("FAIL reset_status busy=%b done=%b hold=%b, want 0 0 1", busy, done, mcu_hold);
        end
        n_cmp++;
        if (bank_we !== 8'h00 || rom_ce !== 1'b0 || rom_addr !== 4'd0 || bank_addr !== 2'd0 || bank_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs we=%h ce=%b ra=%0d ba=%0d wd=%h, want all zero",
                     bank_we, rom_ce, rom_addr, bank_addr, bank_wdata);
        end
        rst   = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mcu_hold !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle_stays busy=%b hold=%b, want 0 1", busy, mcu_hold);
        end
    endtask

    task automatic test_format();
        rom_override = 1'b1;
        rom_force    = 16'h8001;
        tick();
        #1;
        n_cmp++;
        if (bank_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL fmt_idle_zero wdata=%h, want 00000000", bank_wdata);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        n_cmp++;
        if (bank_wdata !== 32'hFF800100) begin
            n_err++;
            $display("FAIL fmt_8001 wdata=%h, want ff800100", bank_wdata);
        end
        rom_force = 16'h7FFF;
        #1;
        n_cmp++;
        if (bank_wdata !== 32'h007FFF00) begin
            n_err++;
            $display("FAIL fmt_7fff wdata=%h, want 007fff00", bank_wdata);
        end
        rom_force = 16'hFFFF;
        #1;
        n_cmp++;
        if (bank_wdata !== 32'hFFFFFF00) begin
            n_err++;
            $display("FAIL fmt_ffff wdata=%h, want ffffff00", bank_wdata);
        end
        do_reset();
        rom_override = 1'b0;
    endtask

    task automatic test_load();
        int b;
        int a;
        for (int i = 0; i < 8; i++) begin
            bank_mem[i][0] = '0;
            bank_mem[i][1] = '0;
        end
        tick();
        start = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mcu_hold !== 1'b1 || bank_we !== 8'h00) begin
            n_err++;
            $display("FAIL load_cycle0 busy=%b hold=%b we=%h, want 0 1 00", busy, mcu_hold, bank_we);
        end
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            #1;
            b = (c - 1) / 2;
            a = (c - 1) % 2;
            n_cmp++;
            if (bank_we !== 8'(1 << b) || bank_addr !== 2'(a) || bank_wdata !== (32'(c) << 8) ||
                rom_addr !== 4'(c - 1) || rom_ce !== 1'b1 || busy !== 1'b1 || mcu_hold !== 1'b1) begin
                n_err++;
                $display("FAIL load_write c=%0d we=%h ba=%0d wd=%h ra=%0d ce=%b, want we=%h ba=%0d wd=%h ra=%0d ce=1",
                         c, bank_we, bank_addr, bank_wdata, rom_addr, rom_ce, 8'(1 << b), a, 32'(c) << 8, c - 1);
            end
            for (int i = 0; i < 8; i++)
                if (bank_we[i] === 1'b1) bank_mem[i][bank_addr[0]] = bank_wdata;
            tick();
        end
        #1;
        n_cmp++;
        if (done !== 1'b1 || mcu_hold !== 1'b0 || busy !== 1'b0 || bank_we !== 8'h00 || rom_ce !== 1'b0) begin
            n_err++;
            $display("FAIL load_done17 done=%b hold=%b busy=%b we=%h ce=%b, want 1 0 0 00 0",
                     done, mcu_hold, busy, bank_we, rom_ce);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (bank_mem[i][0] !== (32'(2 * i + 1) << 8) || bank_mem[i][1] !== (32'(2 * i + 2) << 8)) begin
                n_err++;
                $display("FAIL load_bank%0d a0=%h a1=%h, want %h %h", i, bank_mem[i][0], bank_mem[i][1],
                         32'(2 * i + 1) << 8, 32'(2 * i + 2) << 8);
            end
        end
        do_reset();
    endtask

    task automatic test_stall();
        int exp_k;
        int writes;
        int done_cycle;
        exp_k      = 0;
        writes     = 0;
        done_cycle = -1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24 && done_cycle < 0; c++) begin
            stall = (c >= 6 && c <= 8);
            #1;
            if (done === 1'b1) begin
                done_cycle = c;
            end else begin
                n_cmp++;
                if (stall) begin
                    if (bank_we !== 8'h00 || rom_addr !== 4'(exp_k)) begin
                        n_err++;
                        $display("FAIL stall_hold c=%0d we=%h ra=%0d, want 00 %0d", c, bank_we, rom_addr, exp_k);
                    end
                end else begin
                    if (bank_we !== 8'(1 << (exp_k / 2)) || rom_addr !== 4'(exp_k) || bank_addr !== 2'(exp_k % 2)) begin
                        n_err++;
                        $display("FAIL stall_write c=%0d we=%h ra=%0d ba=%0d, want %h %0d %0d",
                                 c, bank_we, rom_addr, bank_addr, 8'(1 << (exp_k / 2)), exp_k, exp_k % 2);
                    end
                    if (bank_we !== 8'h00) writes++;
                    exp_k++;
                end
            end
            tick();
        end
        stall = 1'b0;
        n_cmp++;
        if (done_cycle != 20 || writes != 16) begin
            n_err++;
            $display("FAIL stall_done done_cycle=%0d writes=%0d, want 20 16", done_cycle, writes);
        end
        do_reset();
        tick();
        start = 1'b1;
        stall = 1'b1;
        tick();
        start = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || bank_we !== 8'h00 || rom_addr !== 4'd0) begin
            n_err++;
            $display("FAIL start_stall_first busy=%b we=%h ra=%0d, want 1 00 0", busy, bank_we, rom_addr);
        end
        stall = 1'b0;
        #1;
        n_cmp++;
        if (bank_we !== 8'h01 || bank_addr !== 2'd0) begin
            n_err++;
            $display("FAIL start_stall_release we=%h ba=%0d, want 01 0", bank_we, bank_addr);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int writes;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        #1;
        n_cmp++;
        if (rom_addr !== 4'd9 || bank_we !== 8'h10 || bank_addr !== 2'd1) begin
            n_err++;
            $display("FAIL rstmid_k9 ra=%0d we=%h ba=%0d, want 9 10 1", rom_addr, bank_we, bank_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || mcu_hold !== 1'b1 || bank_we !== 8'h00 ||
            rom_ce !== 1'b0 || rom_addr !== 4'd0 || bank_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_idle busy=%b done=%b hold=%b we=%h ce=%b ra=%0d wd=%h, want 0 0 1 00 0 0 0",
                     busy, done, mcu_hold, bank_we, rom_ce, rom_addr, bank_wdata);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        writes = 0;
        for (int c = 1; c <= 16; c++) begin
            #1;
            n_cmp++;
            if (rom_addr !== 4'(c - 1) || bank_we !== 8'(1 << ((c - 1) / 2))) begin
                n_err++;
                $display("FAIL rstmid_reload c=%0d ra=%0d we=%h, want %0d %h", c, rom_addr, bank_we, c - 1, 8'(1 << ((c - 1) / 2)));
            end
            if (bank_we !== 8'h00) writes++;
            tick();
        end
        #1;
        n_cmp++;
        if (done !== 1'b1 || writes != 16) begin
            n_err++;
            $display("FAIL rstmid_done done=%b writes=%0d, want 1 16", done, writes);
        end
        do_reset();
    endtask

    task automatic test_restart();
        int writes;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            start = (c == 5);
            #1;
            n_cmp++;
            if (rom_addr !== 4'(c - 1) || bank_we === 8'h00) begin
                n_err++;
                $display("FAIL restart_ignore c=%0d ra=%0d we=%h, want ra=%0d with a write", c, rom_addr, bank_we, c - 1);
            end
            tick();
        end
        start = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b1 || mcu_hold !== 1'b0) begin
            n_err++;
            $display("FAIL restart_done1 done=%b hold=%b, want 1 0", done, mcu_hold);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        n_cmp++;
        if (mcu_hold !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rom_addr !== 4'd0 || bank_we !== 8'h01) begin
            n_err++;
            $display("FAIL restart_reenter hold=%b busy=%b done=%b ra=%0d we=%h, want 1 1 0 0 01",
                     mcu_hold, busy, done, rom_addr, bank_we);
        end
        writes = 0;
        for (int c = 1; c <= 16; c++) begin
            #1;
            if (bank_we !== 8'h00 && rom_addr === 4'(c - 1)) writes++;
            tick();
        end
        #1;
        n_cmp++;
        if (writes != 16 || done !== 1'b1) begin
            n_err++;
            $display("FAIL restart_reload writes=%0d done=%b, want 16 1", writes, done);
        end
        do_reset();
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        start        = 1'b0;
        stall        = 1'b0;
        rom_override = 1'b0;
        rom_force    = 16'h0;
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'(i + 1);

        test_reset();
        test_format();
        test_load();
        test_stall();
        test_reset_mid();
        test_restart();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
